// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one 16-bit signed divider among NREQ requesters; grant one cycle after request.
// Operands stay registered through the divide; the response holds on resp_valid until resp_ready, with divide-by-zero and watchdog bypasses.
module div_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [16*NREQ-1:0]     a_in,
  input  logic [16*NREQ-1:0]     b_in,
  output logic [NREQ-1:0]        gnt,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [2:0]             resp_id,
  output logic [15:0]            resp_result,
  output logic                   resp_z,
  output logic                   resp_n,
  output logic                   resp_c,
  output logic                   resp_v,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   div_start,
  output logic [15:0]            div_a,
  output logic [15:0]            div_b,
  input  logic [15:0]            div_result,
  input  logic                   div_done,
  input  logic                   div_z,
  input  logic                   div_n,
  input  logic                   div_c,
  input  logic                   div_v
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [15:0]     div_a_q, div_a_d;
  logic [15:0]     div_b_q, div_b_d;
  logic [2:0]      resp_id_q, resp_id_d;
  logic [15:0]     resp_result_q, resp_result_d;
  logic            resp_z_q, resp_z_d;
  logic            resp_n_q, resp_n_d;
  logic            resp_c_q, resp_c_d;
  logic            resp_v_q, resp_v_d;
  logic            resp_err_q, resp_err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [7:0]      req_ext;
  logic [3:0]      idx;
  logic            found;
  logic [2:0]      win;
  logic [2:0]      rr_next;
  logic [NREQ-1:0] win_onehot;
  logic [15:0]     sel_a, sel_b;

  // Scan from the highest rotation offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = req;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr_q} + 4'(k);
      if (idx >= 4'(NREQ)) begin
        idx = idx - 4'(NREQ);
      end
      if (req_ext[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
  end

  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        sel_a         = a_in[16*i +: 16];
        sel_b         = b_in[16*i +: 16];
        win_onehot[i] = 1'b1;
      end
    end
    rr_next = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = '0;
    div_a_d       = div_a_q;
    div_b_d       = div_b_q;
    resp_id_d     = resp_id_q;
    resp_result_d = resp_result_q;
    resp_z_d      = resp_z_q;
    resp_n_d      = resp_n_q;
    resp_c_d      = resp_c_q;
    resp_v_d      = resp_v_q;
    resp_err_d    = resp_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d     = win_onehot;
          rr_ptr_d  = rr_next;
          div_a_d   = sel_a;
          div_b_d   = sel_b;
          resp_id_d = win;
          // Zero divisor never reaches the divider: answer with V set straight away.
          if (sel_b == 16'd0) begin
            resp_result_d = '0;
            resp_z_d      = 1'b0;
            resp_n_d      = 1'b0;
            resp_c_d      = 1'b0;
            resp_v_d      = 1'b1;
            resp_err_d    = 1'b0;
            state_d       = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          resp_result_d = div_result;
          resp_z_d      = div_z;
          resp_n_d      = div_n;
          resp_c_d      = div_c;
          resp_v_d      = div_v;
          resp_err_d    = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          resp_result_d = '0;
          resp_z_d      = 1'b0;
          resp_n_d      = 1'b0;
          resp_c_d      = 1'b0;
          resp_v_d      = 1'b1;
          resp_err_d    = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_z_q      <= 1'b0;
      resp_n_q      <= 1'b0;
      resp_c_q      <= 1'b0;
      resp_v_q      <= 1'b0;
      resp_err_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      div_a_q       <= div_a_d;
      div_b_q       <= div_b_d;
      resp_id_q     <= resp_id_d;
      resp_result_q <= resp_result_d;
      resp_z_q      <= resp_z_d;
      resp_n_q      <= resp_n_d;
      resp_c_q      <= resp_c_d;
      resp_v_q      <= resp_v_d;
      resp_err_q    <= resp_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign div_start   = (state_q == ISSUE);
  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign resp_id     = resp_id_q;
  assign resp_result = resp_result_q;
  assign resp_z      = resp_z_q;
  assign resp_n      = resp_n_q;
  assign resp_c      = resp_c_q;
  assign resp_v      = resp_v_q;
  assign resp_err    = resp_err_q;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares the single 16-bit signed divider (`div`) between `NREQ` requesters in the ALU complex. It captures the winning operands, issues a one-cycle start to the divider and holds its inputs stable. It waits for completion, then returns quotient and flags on a response port with ready/valid backpressure. Divide-by-zero is answered without occupying the divider, and a watchdog bounds a hung divider.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before a forced error response; at least 1.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: per-requester request level.
- `a_in`, in, 16*NREQ: packed dividends; requester i uses bits [16i+15:16i].
- `b_in`, in, 16*NREQ: packed divisors, same packing as `a_in`.
- `gnt`, out, NREQ: one-hot, one-cycle pulse meaning the operands were accepted.
- `resp_valid`, out, 1: response available.
- `resp_ready`, in, 1: response consumer accepts.
- `resp_id`, out, 3: index of the served requester.
- `resp_result`, out, 16: signed quotient.
- `resp_z`, out, 1: Z flag of the response.
- `resp_n`, out, 1: N flag of the response.
- `resp_c`, out, 1: C flag of the response.
- `resp_v`, out, 1: V flag of the response.
- `resp_err`, out, 1: response was forced by timeout.
- `busy`, out, 1: high whenever state is not IDLE.
- `div_start`, out, 1: start pulse to the divider.
- `div_a`, out, 16: registered dividend to the divider.
- `div_b`, out, 16: registered divisor to the divider.
- `div_result`, in, 16: quotient from the divider.
- `div_done`, in, 1: divider completion.
- `div_z`, in, 1: Z flag from the divider.
- `div_n`, in, 1: N flag from the divider.
- `div_c`, in, 1: C flag from the divider.
- `div_v`, in, 1: V flag from the divider.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE, on an edge with `req` nonzero:**
  - Select the first set bit at or above `rr_ptr`, wrapping modulo NREQ.
  - Latch that requester's a/b into `div_a`/`div_b` and its index into `resp_id`.
  - Set `gnt` to the one-hot of the winner for exactly one cycle.
  - Set `rr_ptr` to (winner+1) mod NREQ.
- **IDLE, selected b == 0:** go directly to RESP. Response is `resp_result`=0, Z=0, N=0, C=0, V=1, `resp_err`=0, and `div_start` is never asserted.
- **IDLE, selected b != 0:** go to ISSUE.
- **ISSUE:** `div_start`=1 for this cycle only, then go to WAIT. Clear the watchdog counter.
- **WAIT:**
  - The counter increments each cycle.
  - On an edge with `div_done`=1, capture `div_result` and all four flags into the response registers, set `resp_err`=0, and go to RESP.
  - When the counter reaches TIMEOUT without `div_done`, go to RESP with result 0, Z=0, N=0, C=0, V=1, `resp_err`=1.
  - If `div_done` and timeout occur on the same edge, `div_done` wins.
- **RESP:**
  - `resp_valid`=1; all resp_* outputs are held stable.
  - On an edge with `resp_ready`=1, clear `resp_valid` and return to IDLE.
- `div_a`/`div_b` are held unchanged from capture until the next capture, so they are stable through the whole divide.
- `div_done` is ignored in every state except WAIT.
- Requests are sampled only in IDLE. A requester must hold `req` and its operands until `gnt`, then drop `req`. `req` still high after its own response makes that requester eligible again, subject to round-robin order.
- Flags are passed through unmodified except on the fast path and the timeout path.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `gnt`=0, `div_start`=0, `div_a`/`div_b`=0, `resp_valid`=0, `resp_id`=0, `resp_result`=0, all `resp_*` flags=0, `resp_err`=0, `busy`=0.
- The request is sampled at edge E0. `gnt` and `div_start` are both high in cycle E0..E1.
- `resp_valid` rises one cycle after the edge on which `div_done` is sampled high.
- Divide-by-zero: `gnt` and `resp_valid` rise in the same cycle, one cycle after E0.
- With `resp_ready` held high, RESP lasts one cycle and IDLE lasts one cycle, so a back-to-back grant occurs no sooner than the cycle after the IDLE edge.
- Synchronous `rst` in any state, including mid-WAIT, returns all outputs to reset values on that edge. The in-flight result is discarded and no response is produced. `rst` is shared with the divider.

## Test plan
- **Basic positive divide:** req[0] with a=100, b=7 → one `gnt[0]` pulse and one `div_start` pulse; `resp_result`=14 (0x000E), Z=N=V=0, `resp_id`=0.
- **Signed divide:** req[1] with a=0xFF9C (-100), b=7 → `resp_result`=0xFFF2, N=1, `resp_id`=1; `div_a`/`div_b` stable for the entire WAIT.
- **Divide-by-zero fast path:** a=5, b=0 → `div_start` never rises; `resp_valid` rises 1 cycle after E0; result=0, V=1, `resp_err`=0.
- **Round-robin fairness:** req=2'b11 held continuously, `resp_ready`=1 → grant order 0,1,0,1; `resp_id` follows the same sequence.
- **Backpressure:** `resp_ready`=0 for 10 cycles in RESP → `resp_valid` and all response outputs stay constant, no new `gnt`; `resp_ready`=1 → returns to IDLE on that edge.
- **Watchdog and reset:**
  - Stub divider never asserts `div_done`, TIMEOUT=8 → response after 8 WAIT cycles with V=1, `resp_err`=1.
  - Repeat the request and assert `rst` mid-WAIT → `busy`=0 and `resp_valid`=0 on the next cycle, no response.
